// File: rtl/if_stage_fq.sv
// Instruction fetch stage with pipelined inst SRAM requests and a fetch queue.
// Optional zero-latency response bypass to ID: define FQ_BYPASS_EN.

`ifndef FS_TO_DS_BUS_WD
`define FS_TO_DS_BUS_WD 71
`endif
`ifndef ECODE_ADE
`define ECODE_ADE 6'h08
`endif

module if_stage_fq #(
    parameter int          FQ_DEPTH        = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ds_allowin,
    output logic                        fs_to_ds_valid,
    output logic [`FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    input  logic                        br_taken,
    input  logic [31:0]                 br_target,
    input  logic                        fs_flush_pipe,
    input  logic [31:0]                 ws_to_fs_bus,
    output logic [31:0]                 tr_va,
    input  logic [31:0]                 tr_pa,
    input  logic                        tr_ex,
    input  logic [5:0]                  tr_ecode,
    output logic                        inst_sram_req,
    output logic                        inst_sram_wr,
    output logic [1:0]                  inst_sram_size,
    output logic [3:0]                  inst_sram_wstrb,
    output logic [31:0]                 inst_sram_addr,
    output logic [31:0]                 inst_sram_wdata,
    input  logic                        inst_sram_addr_ok,
    input  logic                        inst_sram_data_ok,
    input  logic [31:0]                 inst_sram_rdata
);

    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int QAW = $clog2(FQ_DEPTH);
    localparam int QCW = $clog2(FQ_DEPTH + 1);
    localparam int BW  = `FS_TO_DS_BUS_WD;

    logic [31:0]    fetch_pc;
    logic           halt;
    logic [CW-1:0]  outst_cnt;
    logic [CW-1:0]  outst_next;
    logic [CW-1:0]  discard_cnt;

    logic [31:0]    pcq [MAX_OUTSTANDING];
    logic [PAW-1:0] pq_wr;
    logic [PAW-1:0] pq_rd;

    logic [BW-1:0]  fq_mem [FQ_DEPTH];
    logic [QAW-1:0] fq_wr;
    logic [QAW-1:0] fq_rd;
    logic [QCW-1:0] fq_cnt;

    logic           redirect;
    logic [31:0]    target;
    logic           misalign;
    logic           fetch_ex;
    logic [5:0]     fetch_ecode;
    logic           fq_full;
    logic           fq_empty;
    logic           outst_ok;
    logic           credit_ok;
    logic           accept;
    logic           resp;
    logic           drop;
    logic           keep;
    logic           exc_push;
    logic           bypass;
    logic           fq_push;
    logic           fq_pop;
    logic [BW-1:0]  resp_entry;
    logic [BW-1:0]  fq_wdata;

    function automatic logic [PAW-1:0] pq_inc(input logic [PAW-1:0] p);
        return (p == PAW'(MAX_OUTSTANDING - 1)) ? '0 : p + PAW'(1);
    endfunction

    assign redirect    = fs_flush_pipe | br_taken;
    assign target      = fs_flush_pipe ? ws_to_fs_bus : br_target;
    assign misalign    = fetch_pc[1:0] != 2'b00;
    assign fetch_ex    = misalign | tr_ex;
    assign fetch_ecode = misalign ? `ECODE_ADE : tr_ecode;

    assign fq_full   = fq_cnt == QCW'(FQ_DEPTH);
    assign fq_empty  = fq_cnt == '0;
    assign outst_ok  = outst_cnt < CW'(MAX_OUTSTANDING);
    // Queue slots are reserved for every in-flight request up front.
    assign credit_ok = (32'(fq_cnt) + 32'(outst_cnt)) < 32'(FQ_DEPTH);

    assign inst_sram_req   = !reset & !redirect & !halt & !fetch_ex
                           & outst_ok & credit_ok;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;
    assign inst_sram_addr  = tr_pa;
    assign tr_va           = fetch_pc;

    assign accept = inst_sram_req & inst_sram_addr_ok;
    assign resp   = inst_sram_data_ok & (outst_cnt != '0);
    assign drop   = resp & (redirect | (discard_cnt != '0));
    assign keep   = resp & !drop;

    assign exc_push = fetch_ex & !halt & !redirect
                    & (outst_cnt == '0) & !fq_full;

    assign resp_entry = {6'h0, 1'b0, inst_sram_rdata, pcq[pq_rd]};

`ifdef FQ_BYPASS_EN
    assign bypass = !reset & keep & fq_empty & ds_allowin;
`else
    assign bypass = 1'b0;
`endif

    assign fq_push  = (keep & !bypass) | exc_push;
    assign fq_wdata = exc_push ? {fetch_ecode, 1'b1, 32'h0, fetch_pc}
                               : resp_entry;
    assign fq_pop   = fs_to_ds_valid & ds_allowin & !fq_empty;

    assign fs_to_ds_valid = !reset & !redirect & (!fq_empty | bypass);
    assign fs_to_ds_bus   = bypass   ? resp_entry :
                            fq_empty ? '0         : fq_mem[fq_rd];

    assign outst_next = outst_cnt + CW'(accept) - CW'(resp);

    always_ff @(posedge clk) begin
        if (accept) pcq[pq_wr] <= fetch_pc;
        if (fq_push) fq_mem[fq_wr] <= fq_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            halt        <= 1'b0;
            outst_cnt   <= '0;
            discard_cnt <= '0;
            pq_wr       <= '0;
            pq_rd       <= '0;
            fq_wr       <= '0;
            fq_rd       <= '0;
            fq_cnt      <= '0;
        end else begin
            outst_cnt <= outst_next;
            if (accept) pq_wr <= pq_inc(pq_wr);
            if (resp) pq_rd <= pq_inc(pq_rd);
            if (redirect) begin
                // Everything still in flight belongs to the old path.
                discard_cnt <= outst_next;
                fetch_pc    <= target;
                halt        <= 1'b0;
                fq_wr       <= '0;
                fq_rd       <= '0;
                fq_cnt      <= '0;
            end else begin
                if (resp && discard_cnt != '0)
                    discard_cnt <= discard_cnt - CW'(1);
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                if (exc_push) halt <= 1'b1;
                if (fq_push) fq_wr <= fq_wr + QAW'(1);
                if (fq_pop) fq_rd <= fq_rd + QAW'(1);
                fq_cnt <= fq_cnt + QCW'(fq_push) - QCW'(fq_pop);
            end
        end
    end

endmodule

// File: tb/tb_if_stage_fq.sv
// Directed scoreboard bench for if_stage_fq with a simple ordered inst SRAM model.
// Behaves correctly with or without FQ_BYPASS_EN defined.

module tb_if_stage_fq;

    localparam logic [31:0] OFF  = 32'h2000_0000;
    localparam logic [5:0]  ADE  = 6'h08;
    localparam logic [5:0]  TLBR = 6'h3f;
`ifdef FQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        reset;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [70:0] fs_to_ds_bus;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_flush_pipe;
    logic [31:0] ws_to_fs_bus;
    logic [31:0] tr_va;
    logic [31:0] tr_pa;
    logic        tr_ex;
    logic [5:0]  tr_ecode;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    if_stage_fq dut (
        .clk(clk), .reset(reset), .ds_allowin(ds_allowin),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .br_taken(br_taken), .br_target(br_target),
        .fs_flush_pipe(fs_flush_pipe), .ws_to_fs_bus(ws_to_fs_bus),
        .tr_va(tr_va), .tr_pa(tr_pa), .tr_ex(tr_ex), .tr_ecode(tr_ecode),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata)
    );

    assign tr_pa = tr_va + OFF;

    typedef struct {
        logic [31:0] pa;
        logic [31:0] pc;
        bit          stale;
    } req_t;

    req_t        pending[$];
    logic [70:0] sb[$];
    logic [31:0] exp_pc;
    logic [70:0] last_del;
    bit          resp_en;
    int          n_checks;
    int          n_pass;
    int          cyc;
    int          first_acc;
    int          first_val;
    int          accepts;
    int          deliveries;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5a5a_0f0f;
    endfunction

    task automatic check(input string tag, input logic [70:0] obs,
                         input logic [70:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ordered SRAM: answers one cycle after accept when enabled.
    always @(posedge clk) begin
        #2;
        if (!reset && resp_en && pending.size() > 0) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = mem(pending[0].pa);
        end else begin
            inst_sram_data_ok = 1'b0;
            inst_sram_rdata   = 32'h0;
        end
    end

    // Reference model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        req_t e;
        bit   redir;
        cyc++;
        if (reset) begin
            pending.delete();
            sb.delete();
            exp_pc    = 32'h1c000000;
            first_acc = -1;
            first_val = -1;
        end else begin
            redir = br_taken | fs_flush_pipe;
            if (redir) begin
                check("req_on_redirect", 71'(inst_sram_req), 71'(0));
                check("valid_on_redirect", 71'(fs_to_ds_valid), 71'(0));
            end
            if (inst_sram_data_ok && pending.size() > 0) begin
                e = pending.pop_front();
                if (!e.stale && !redir)
                    sb.push_back({6'h0, 1'b0, mem(e.pc + OFF), e.pc});
            end
            if (fs_to_ds_valid && ds_allowin) begin
                check("deliver_expected", 71'(sb.size() != 0), 71'(1));
                if (sb.size() != 0)
                    check("deliver_entry", fs_to_ds_bus, sb.pop_front());
                last_del = fs_to_ds_bus;
                deliveries++;
                if (first_val < 0) first_val = cyc;
            end
            if (inst_sram_req && inst_sram_addr_ok) begin
                check("accept_va", 71'(tr_va), 71'(exp_pc));
                check("accept_pa", 71'(inst_sram_addr), 71'(exp_pc + OFF));
                e.pa    = inst_sram_addr;
                e.pc    = exp_pc;
                e.stale = 1'b0;
                pending.push_back(e);
                exp_pc = exp_pc + 32'd4;
                accepts++;
                if (first_acc < 0) first_acc = cyc;
            end
            if (redir) begin
                foreach (pending[i]) pending[i].stale = 1'b1;
                sb.delete();
                exp_pc = fs_flush_pipe ? ws_to_fs_bus : br_target;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        int a0;
        n_checks          = 0;
        n_pass            = 0;
        cyc               = 0;
        accepts           = 0;
        deliveries        = 0;
        first_acc         = -1;
        first_val         = -1;
        last_del          = '0;
        exp_pc            = 32'h1c000000;
        reset             = 1'b1;
        ds_allowin        = 1'b1;
        br_taken          = 1'b0;
        br_target         = 32'h0;
        fs_flush_pipe     = 1'b0;
        ws_to_fs_bus      = 32'h0;
        tr_ex             = 1'b0;
        tr_ecode          = 6'h0;
        inst_sram_addr_ok = 1'b1;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
        resp_en           = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", 71'(inst_sram_req), 71'(0));
        check("rst_valid", 71'(fs_to_ds_valid), 71'(0));
        check("rst_bus", fs_to_ds_bus, 71'(0));
        check("const_wr", 71'(inst_sram_wr), 71'(0));
        check("const_size", 71'(inst_sram_size), 71'(2));
        check("const_wstrb", 71'(inst_sram_wstrb), 71'(0));
        check("const_wdata", 71'(inst_sram_wdata), 71'(0));
        @(posedge clk);
        #1 reset = 1'b0;

        // Streaming fetch from the reset PC
        for (int i = 0; i < 10 && deliveries == 0; i++) tick(1);
        check("first_delivery_seen", 71'(deliveries > 0), 71'(1));
        check("first_latency", 71'(first_val - first_acc), 71'(LAT));
        tick(16);
        check("throughput", 71'(deliveries >= 15), 71'(1));

        // ID stall: queue fills to depth and request stops
        ds_allowin = 1'b0;
        tick(10);
        check("stall_sb_full", 71'(sb.size()), 71'(4));
        check("stall_no_outst", 71'(pending.size()), 71'(0));
        @(negedge clk);
        check("stall_req_low", 71'(inst_sram_req), 71'(0));
        check("stall_valid", 71'(fs_to_ds_valid), 71'(1));
        @(posedge clk);
        #1 d0 = deliveries;
        ds_allowin = 1'b1;
        tick(6);
        check("release_drain", 71'(deliveries - d0 >= 4), 71'(1));

        // Branch with two requests in flight
        resp_en = 1'b0;
        for (int i = 0; i < 12 && !(pending.size() == 2 && sb.size() == 0); i++)
            tick(1);
        check("two_outstanding", 71'(pending.size()), 71'(2));
        check("queue_drained", 71'(sb.size()), 71'(0));
        br_taken  = 1'b1;
        br_target = 32'h1c000100;
        tick(1);
        br_taken = 1'b0;
        resp_en  = 1'b1;
        d0 = deliveries;
        for (int i = 0; i < 12 && deliveries == d0; i++) tick(1);
        check("branch_first_pc", 71'(last_del[31:0]), 71'(32'h1c000100));

        // Flush and branch together while the queue is full
        ds_allowin = 1'b0;
        tick(10);
        check("full_before_flush", 71'(sb.size()), 71'(4));
        br_taken      = 1'b1;
        br_target     = 32'h1c000200;
        fs_flush_pipe = 1'b1;
        ws_to_fs_bus  = 32'h1c008000;
        ds_allowin    = 1'b1;
        tick(1);
        br_taken      = 1'b0;
        fs_flush_pipe = 1'b0;
        d0 = deliveries;
        for (int i = 0; i < 12 && deliveries == d0; i++) tick(1);
        check("flush_wins_pc", 71'(last_del[31:0]), 71'(32'h1c008000));

        // Misaligned target: single ADE entry then halt
        br_taken  = 1'b1;
        br_target = 32'h1c000102;
        tick(1);
        br_taken = 1'b0;
        sb.push_back({ADE, 1'b1, 32'h0, 32'h1c000102});
        a0 = accepts;
        d0 = deliveries;
        tick(10);
        check("ade_no_accept", 71'(accepts - a0), 71'(0));
        check("ade_one_entry", 71'(deliveries - d0), 71'(1));
        check("ade_entry", last_del, {ADE, 1'b1, 32'h0, 32'h1c000102});
        @(negedge clk);
        check("halt_req_low", 71'(inst_sram_req), 71'(0));

        // TLB exception ordered behind an outstanding response
        @(posedge clk);
        #1 resp_en = 1'b0;
        br_taken  = 1'b1;
        br_target = 32'h1c000300;
        tick(1);
        br_taken = 1'b0;
        tick(1);
        inst_sram_addr_ok = 1'b0;
        tr_ex    = 1'b1;
        tr_ecode = TLBR;
        d0 = deliveries;
        tick(3);
        check("tlbr_one_outst", 71'(pending.size()), 71'(1));
        check("tlbr_waits", 71'(deliveries - d0), 71'(0));
        resp_en = 1'b1;
        tick(1);
        sb.push_back({TLBR, 1'b1, 32'h0, 32'h1c000304});
        tick(6);
        check("tlbr_two_entries", 71'(deliveries - d0), 71'(2));
        check("tlbr_entry", last_del, {TLBR, 1'b1, 32'h0, 32'h1c000304});
        check("sb_empty_end", 71'(sb.size()), 71'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
